// File: rtl/tempsense_host_reader.sv
// Host-side reader: sends CMD_BYTE over 8N1 serial, gathers a 3-byte reply into a 24-bit result.
// Optional per-byte response watchdog enabled by defining READER_TIMEOUT_EN.
module tempsense_host_reader #(
    parameter int         CLK_FREQ       = 10000,
    parameter int         BAUD           = 1000,
    parameter logic [7:0] CMD_BYTE       = 8'h01,
    parameter int         TIMEOUT_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rx,
    output logic        tx,
    output logic        busy,
    output logic [23:0] result,
    output logic        result_valid,
    output logic        framing_err,
    output logic        timeout_err
);
    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int CW      = $clog2(BIT_CYC + 1);
    localparam logic [CW-1:0] C_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] C_HALF = CW'(BIT_CYC / 2 - 1);

    typedef enum logic [2:0] {IDLE, SEND_CMD, WAIT_B0, WAIT_B1, WAIT_B2, DONE} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    state_t      r_state, w_state_nxt;
    rx_state_t   r_rx_state, w_rx_nxt;
    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]  r_rx_bits;
    logic [7:0]  r_rx_sh;
    logic        r_rx_done, r_rx_ferr;
    logic [9:0]  r_tx_sh;
    logic [CW-1:0] r_tx_cyc;
    logic [3:0]  r_tx_bit;
    logic [1:0]  r_idx, w_idx_nxt;
    logic [23:0] r_stage, w_stage_nxt, r_result;
    logic        w_accept, w_tx_last, w_timeout;

    // Receiver runs regardless of the host FSM; it only reports finished bytes.
    always_comb begin
        w_rx_nxt = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_nxt = RX_START;
            RX_START: if (r_rx_cnt == C_HALF) w_rx_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (r_rx_cnt == C_LAST && r_rx_bits == 3'd7) w_rx_nxt = RX_STOP;
            RX_STOP:  if (r_rx_cnt == C_LAST) w_rx_nxt = RX_IDLE;
            default:  w_rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bits  <= '0;
            r_rx_sh    <= '0;
            r_rx_done  <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_meta  <= rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_nxt;
            r_rx_done  <= 1'b0;
            r_rx_ferr  <= 1'b0;
            if (r_rx_state == RX_IDLE || w_rx_nxt != r_rx_state || r_rx_cnt == C_LAST)
                r_rx_cnt <= '0;
            else
                r_rx_cnt <= r_rx_cnt + 1'b1;
            if (r_rx_state == RX_START) r_rx_bits <= '0;
            if (r_rx_state == RX_DATA && r_rx_cnt == C_LAST) begin
                r_rx_sh   <= {r_rx_sync, r_rx_sh[7:1]};
                r_rx_bits <= r_rx_bits + 1'b1;
            end
            if (r_rx_state == RX_STOP && r_rx_cnt == C_LAST) begin
                r_rx_done <= r_rx_sync;
                r_rx_ferr <= ~r_rx_sync;
            end
        end
    end

    assign w_tx_last = (r_state == SEND_CMD) && (r_tx_bit == 4'd9) && (r_tx_cyc == C_LAST);
    assign w_accept  = r_rx_done && (r_state inside {SEND_CMD, WAIT_B0, WAIT_B1, WAIT_B2});
    assign w_idx_nxt = r_idx + {1'b0, w_accept};

    always_comb begin
        w_stage_nxt = r_stage;
        if (w_accept) begin
            case (r_idx)
                2'd0:    w_stage_nxt[7:0]   = r_rx_sh;
                2'd1:    w_stage_nxt[15:8]  = r_rx_sh;
                default: w_stage_nxt[23:16] = r_rx_sh;
            endcase
        end
    end

    // A reply byte may already land while the command is still going out.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (start) w_state_nxt = SEND_CMD;
            SEND_CMD: begin
                if (r_rx_ferr) w_state_nxt = IDLE;
                else if (w_tx_last) begin
                    case (w_idx_nxt)
                        2'd0:    w_state_nxt = WAIT_B0;
                        2'd1:    w_state_nxt = WAIT_B1;
                        2'd2:    w_state_nxt = WAIT_B2;
                        default: w_state_nxt = DONE;
                    endcase
                end
            end
            WAIT_B0:  if (r_rx_ferr || w_timeout) w_state_nxt = IDLE;
                      else if (w_accept) w_state_nxt = WAIT_B1;
            WAIT_B1:  if (r_rx_ferr || w_timeout) w_state_nxt = IDLE;
                      else if (w_accept) w_state_nxt = WAIT_B2;
            WAIT_B2:  if (r_rx_ferr || w_timeout) w_state_nxt = IDLE;
                      else if (w_accept) w_state_nxt = DONE;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_stage  <= '0;
            r_result <= '0;
            r_tx_sh  <= '1;
            r_tx_cyc <= '0;
            r_tx_bit <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE) begin
                r_idx    <= '0;
                r_stage  <= '0;
                r_tx_sh  <= {1'b1, CMD_BYTE, 1'b0};
                r_tx_cyc <= '0;
                r_tx_bit <= '0;
            end else begin
                r_idx   <= w_idx_nxt;
                r_stage <= w_stage_nxt;
                if (r_state == SEND_CMD) begin
                    if (r_tx_cyc == C_LAST) begin
                        r_tx_cyc <= '0;
                        r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
                        r_tx_bit <= r_tx_bit + 1'b1;
                    end else begin
                        r_tx_cyc <= r_tx_cyc + 1'b1;
                    end
                end
            end
            if (w_state_nxt == DONE && r_state != DONE) r_result <= w_stage_nxt;
        end
    end

`ifdef READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wd_cnt;
    logic          w_in_wait, w_wd_clr;

    assign w_in_wait = r_state inside {WAIT_B0, WAIT_B1, WAIT_B2};
    assign w_timeout = w_in_wait && (r_wd_cnt == TW'(TIMEOUT_CYCLES));
    assign w_wd_clr  = ((w_state_nxt inside {WAIT_B0, WAIT_B1, WAIT_B2}) && w_state_nxt != r_state)
                     || (r_rx_state == RX_START && w_rx_nxt == RX_DATA);

    // Counts only while the line is quiet, so a slow but live byte never trips it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wd_cnt <= '0;
        else if (w_wd_clr)
            r_wd_cnt <= '0;
        else if (w_in_wait && r_rx_state == RX_IDLE && !w_timeout)
            r_wd_cnt <= r_wd_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign tx           = (r_state == SEND_CMD) ? r_tx_sh[0] : 1'b1;
    assign busy         = (r_state != IDLE);
    assign result       = r_result;
    assign result_valid = (r_state == DONE);
    assign framing_err  = r_rx_ferr;
    assign timeout_err  = w_timeout;
endmodule

// File: tb/tb_tempsense_host_reader.sv
// Directed bench for tempsense_host_reader: command frame, replies, framing, glitch, reset, watchdog.
module tb_tempsense_host_reader;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx = 1'b1;
    logic        tx, busy, result_valid, framing_err, timeout_err;
    logic [23:0] result;
    int n_cmp = 0, n_fail = 0;
    int n_rv = 0, n_fe = 0, n_to = 0;

    tempsense_host_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx(rx), .tx(tx), .busy(busy),
        .result(result), .result_valid(result_valid), .framing_err(framing_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (result_valid) n_rv++;
        if (framing_err)  n_fe++;
        if (timeout_err)  n_to++;
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        cyc(10);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stp);
        rx = 1'b1;
        cyc(10);
    endtask

    task automatic kick;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(3);
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (result !== 24'h0) begin n_fail++; $display("FAIL reset_result: got %h want 000000", result); end
        n_cmp++; if ({result_valid, framing_err, timeout_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 000", {result_valid, framing_err, timeout_err});
        end
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_tx_frame_and_readout;
        logic [9:0] frame;
        int rv0;
        logic ok;
        frame = {1'b1, 8'h01, 1'b0};
        kick;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tx_busy: got %b want 1", busy); end
        for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int c = 0; c < 10; c++) begin
                if (tx !== frame[b]) ok = 1'b0;
                cyc(1);
            end
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL tx_bit%0d: wrong level, want %b for 10 cycles", b, frame[b]); end
        end
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_idle_after: got %b want 1", tx); end
        rv0 = n_rv;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        n_cmp++; if (result !== 24'h563412) begin n_fail++; $display("FAIL readout_result: got %h want 563412", result); end
        n_cmp++; if (n_rv - rv0 !== 1) begin n_fail++; $display("FAIL readout_valid_count: got %0d want 1", n_rv - rv0); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL readout_busy: got %b want 0", busy); end
    endtask

    task automatic test_framing;
        int rv0, fe0;
        rv0 = n_rv; fe0 = n_fe;
        kick;
        cyc(100);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        n_cmp++; if (n_fe - fe0 !== 1) begin n_fail++; $display("FAIL framing_pulse: got %0d want 1", n_fe - fe0); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL framing_busy: got %b want 0", busy); end
        n_cmp++; if (n_rv !== rv0) begin n_fail++; $display("FAIL framing_no_valid: got %0d want %0d", n_rv, rv0); end
        n_cmp++; if (result !== 24'h563412) begin n_fail++; $display("FAIL framing_result: got %h want 563412", result); end
    endtask

    task automatic test_glitch;
        int rv0, fe0;
        rv0 = n_rv; fe0 = n_fe;
        kick;
        cyc(100);
        rx = 1'b0; cyc(3); rx = 1'b1;
        cyc(20);
        n_cmp++; if (busy !== 1'b1 || n_fe !== fe0) begin
            n_fail++; $display("FAIL glitch_ignored: busy %b fe %0d, want busy 1 fe %0d", busy, n_fe, fe0);
        end
        send_byte(8'h21, 1'b1);
        send_byte(8'h43, 1'b1);
        send_byte(8'h65, 1'b1);
        n_cmp++; if (result !== 24'h654321) begin n_fail++; $display("FAIL glitch_result: got %h want 654321", result); end
        n_cmp++; if (n_rv - rv0 !== 1) begin n_fail++; $display("FAIL glitch_valid_count: got %0d want 1", n_rv - rv0); end
    endtask

    task automatic test_busy_ignore;
        int rv0;
        logic stayed_idle;
        rv0 = n_rv;
        kick;
        cyc(50);
        start = 1'b1; cyc(5); start = 1'b0;
        cyc(50);
        send_byte(8'h0F, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h5A, 1'b1);
        n_cmp++; if (result !== 24'h5AF00F) begin n_fail++; $display("FAIL busy_result: got %h want 5af00f", result); end
        n_cmp++; if (n_rv - rv0 !== 1) begin n_fail++; $display("FAIL busy_valid_count: got %0d want 1", n_rv - rv0); end
        stayed_idle = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (busy !== 1'b0 || tx !== 1'b1) stayed_idle = 1'b0;
            cyc(1);
        end
        n_cmp++; if (!stayed_idle) begin n_fail++; $display("FAIL busy_not_queued: got busy/tx activity want idle"); end
    endtask

    task automatic test_reset_mid;
        int rv0;
        kick;
        cyc(100);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        rst_n = 1'b0;
        cyc(2);
        n_cmp++; if (busy !== 1'b0 || result !== 24'h0) begin
            n_fail++; $display("FAIL midreset_state: busy %b result %h want 0 000000", busy, result);
        end
        rst_n = 1'b1;
        rv0 = n_rv;
        cyc(150);
        n_cmp++; if (n_rv !== rv0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_quiet: rv %0d busy %b want %0d 0", n_rv, busy, rv0);
        end
        kick;
        cyc(100);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        n_cmp++; if (result !== 24'hCCBBAA) begin n_fail++; $display("FAIL midreset_result: got %h want ccbbaa", result); end
        n_cmp++; if (n_rv - rv0 !== 1) begin n_fail++; $display("FAIL midreset_valid_count: got %0d want 1", n_rv - rv0); end
    endtask

    task automatic test_timeout;
        int to0;
        to0 = n_to;
`ifdef READER_TIMEOUT_EN
        begin
            int k;
            k = 0;
            kick;
            while (timeout_err !== 1'b1 && k < 3000) begin cyc(1); k++; end
            n_cmp++; if (k !== 2100) begin n_fail++; $display("FAIL timeout_latency: got %0d want 2100", k); end
            cyc(1);
            n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy); end
            n_cmp++; if (result !== 24'hCCBBAA) begin n_fail++; $display("FAIL timeout_result: got %h want ccbbaa", result); end
            n_cmp++; if (n_to - to0 !== 1) begin n_fail++; $display("FAIL timeout_count: got %0d want 1", n_to - to0); end
        end
`else
        kick;
        cyc(2500);
        n_cmp++; if (busy !== 1'b1 || n_to !== to0) begin
            n_fail++; $display("FAIL no_timeout: busy %b to %0d want 1 %0d", busy, n_to, to0);
        end
        send_byte(8'hDD, 1'b1);
        send_byte(8'hEE, 1'b1);
        send_byte(8'hFF, 1'b1);
        n_cmp++; if (result !== 24'hFFEEDD) begin n_fail++; $display("FAIL late_reply_result: got %h want ffeedd", result); end
`endif
    endtask

    initial begin
        test_reset;
        test_tx_frame_and_readout;
        test_framing;
        test_glitch;
        test_busy_ignore;
        test_reset_mid;
        test_timeout;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
